// File: rtl/sub_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sub_ctrl_pkg
// Brief  : Shared state encoding and $FD05 register layout for the
//          main-to-sub halt/cancel control stage.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package sub_ctrl_pkg;

  // Halt handshake state; encoding is shared with software-visible debug
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2,
    REL    = 2'd3
  } state_t;

  // $FD05 bit positions
  localparam int HALT_BIT   = 7;
  localparam int CANCEL_BIT = 6;
  localparam int EXTDET_BIT = 0;

  // Constant-one fill for readback bits 6:1
  localparam logic [5:0] RD_FILL = 6'b111111;

endpackage : sub_ctrl_pkg
`default_nettype wire

// File: rtl/level_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : level_filter
// Brief  : Saturating run-length counter. Reports "stable" once the input
//          has matched the expected level for FILTER consecutive samples
//          (the current sample included).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module level_filter #(
  parameter int FILTER = 2,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_level,
  input  logic i_match,
  output logic o_stable
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FILTER - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit    = (i_level == i_match);
  assign o_stable = w_hit && (r_cnt == C_LAST);

  // Count consecutive matching samples; stop at the last value rather than wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !w_hit) begin
      r_cnt <= '0;
    end else if (r_cnt != C_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : level_filter
`default_nettype wire

// File: rtl/sub_halt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sub_halt_ctrl
// Brief  : Main-side $FD05 halt/cancel register and sub-side busy/cancel
//          acknowledge; drives SHALTn/SUBIRQn to the sub-CPU wrapper and
//          filters its SHALTSTn halt status.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sub_halt_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int HALT_FILTER = 2,
  parameter int CNT_W       = 4
) (
  input  logic       SCPUCLK,
  input  logic       RESETBn,
  input  logic       MWR_FD05,
  input  logic       MRD_FD05,
  input  logic [7:0] MDATA_in,
  output logic [7:0] MDATA_out,
  input  logic       EXTDET,
  input  logic       SRD_D40A,
  input  logic       SWR_D40A,
  input  logic       SRD_D402,
  input  logic       SHALTSTn,
  output logic       SHALTn,
  output logic       SUBIRQn,
  output logic       SUB_HALTED
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_shaltn;
  logic   r_busy;
  logic   r_cancel;
  logic   w_wr_halt;
  logic   w_wr_rel;
  logic   w_wr_cancel;
  logic   w_active;
  logic   w_clear;
  logic   w_match;
  logic   w_stable;
  logic   w_rd_bit7;
  logic   w_unused;

  assign w_wr_halt   = MWR_FD05 &&  MDATA_in[HALT_BIT];
  assign w_wr_rel    = MWR_FD05 && !MDATA_in[HALT_BIT];
  assign w_wr_cancel = MWR_FD05 &&  MDATA_in[CANCEL_BIT];
  assign w_unused    = ^MDATA_in[5:0];

  // REQ waits for SHALTSTn low, REL waits for it high; counter idles cleared
  // outside those states and restarts on every state change.
  assign w_active = (r_state == REQ) || (r_state == REL);
  assign w_match  = (r_state == REL);
  assign w_clear  = !w_active || (w_state_nxt != r_state);

  level_filter #(
    .FILTER (HALT_FILTER),
    .CNT_W  (CNT_W)
  ) u_level_filter (
    .clk      (SCPUCLK),
    .rst_n    (RESETBn),
    .i_clear  (w_clear),
    .i_level  (SHALTSTn),
    .i_match  (w_match),
    .o_stable (w_stable)
  );

  // Next-state: main writes take priority over a filter completion
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (w_wr_halt) w_state_nxt = REQ;
      REQ:     if (w_wr_rel) w_state_nxt = REL;
               else if (w_stable) w_state_nxt = HALTED;
      HALTED:  if (w_wr_rel) w_state_nxt = REL;
      REL:     if (w_wr_halt) w_state_nxt = REQ;
               else if (w_stable) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // State, registered SHALTn decode, busy and cancel flags (set beats clear)
  always_ff @(posedge SCPUCLK) begin
    if (!RESETBn) begin
      r_state  <= RUN;
      r_shaltn <= 1'b1;
      r_busy   <= 1'b1;
      r_cancel <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shaltn <= !((w_state_nxt == REQ) || (w_state_nxt == HALTED));
      if (SRD_D40A)      r_busy <= 1'b1;
      else if (SWR_D40A) r_busy <= 1'b0;
      if (w_wr_cancel)   r_cancel <= 1'b1;
      else if (SRD_D402) r_cancel <= 1'b0;
    end
  end

  assign SHALTn     = r_shaltn;
  assign SUBIRQn    = ~r_cancel;
  assign SUB_HALTED = (r_state == HALTED);

  // $FD05 readback: transitional states read busy, RUN reflects busy_ff
  always_comb begin
    w_rd_bit7 = 1'b1;
    unique case (r_state)
      RUN:     w_rd_bit7 = r_busy;
      HALTED:  w_rd_bit7 = 1'b0;
      default: w_rd_bit7 = 1'b1;
    endcase
    MDATA_out = 8'hFF;
    if (MRD_FD05) begin
      MDATA_out             = {w_rd_bit7, RD_FILL, 1'b0};
      MDATA_out[EXTDET_BIT] = EXTDET;
    end
  end

endmodule : sub_halt_ctrl
`default_nettype wire

// File: tb/tb_sub_halt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_sub_halt_ctrl
// Brief  : Scoreboard bench for sub_halt_ctrl: directed handshake sequences
//          followed by random traffic, checked against a behavioural model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_sub_halt_ctrl;

  localparam int F = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       mwr, mrd, extdet, srd40a, swr40a, srd402, shst;
  logic [7:0] mdin, mdout;
  logic       shaltn, subirqn, sub_halted;

  always #5 clk = ~clk;

  sub_halt_ctrl #(.HALT_FILTER(F), .CNT_W(4)) dut (
    .SCPUCLK    (clk),
    .RESETBn    (rstn),
    .MWR_FD05   (mwr),
    .MRD_FD05   (mrd),
    .MDATA_in   (mdin),
    .MDATA_out  (mdout),
    .EXTDET     (extdet),
    .SRD_D40A   (srd40a),
    .SWR_D40A   (swr40a),
    .SRD_D402   (srd402),
    .SHALTSTn   (shst),
    .SHALTn     (shaltn),
    .SUBIRQn    (subirqn),
    .SUB_HALTED (sub_halted)
  );

  typedef struct {
    logic       shaltn;
    logic       subirqn;
    logic       halted;
    logic [7:0] rd;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: "want" = main asked for halt, "halted" = sub confirmed,
  // "releasing" = waiting for the sub to run again; streak = consecutive
  // qualifying SHALTSTn samples seen in the current waiting phase.
  bit want = 0, halted = 0, releasing = 0, busy = 1, cancel = 0;
  int streak = 0;

  function automatic exp_t expect_now(bit rd, bit ext);
    exp_t e;
    bit   b7;
    e.shaltn  = !want;
    e.subirqn = !cancel;
    e.halted  = want && halted;
    if (want && halted)                b7 = 1'b0;
    else if (want || releasing)        b7 = 1'b1;
    else                               b7 = busy;
    e.rd = rd ? {b7, 6'h3F, ext} : 8'hFF;
    return e;
  endfunction

  task automatic model_step(bit r, bit wr, bit [7:0] d, bit s40r, bit s40w,
                            bit s402, bit s);
    if (!r) begin
      want = 0; halted = 0; releasing = 0; streak = 0; busy = 1; cancel = 0;
      return;
    end
    if (s40r) busy = 1; else if (s40w) busy = 0;
    if (wr && d[6]) cancel = 1; else if (s402) cancel = 0;
    if (want && !halted) begin
      if (wr && !d[7]) begin want = 0; releasing = 1; streak = 0; end
      else if (!s) begin
        if (streak + 1 >= F) begin halted = 1; streak = 0; end
        else streak++;
      end else streak = 0;
    end else if (want) begin
      if (wr && !d[7]) begin want = 0; halted = 0; releasing = 1; streak = 0; end
    end else if (releasing) begin
      if (wr && d[7]) begin want = 1; releasing = 0; streak = 0; end
      else if (s) begin
        if (streak + 1 >= F) begin releasing = 0; streak = 0; end
        else streak++;
      end else streak = 0;
    end else if (wr && d[7]) begin
      want = 1; streak = 0;
    end
  endtask

  // One clock of stimulus: drive on the falling edge, queue the expected
  // outputs for that window, then advance the model at the rising edge.
  task automatic cyc(bit r, bit wr, bit [7:0] d, bit rd, bit ext, bit s40r,
                     bit s40w, bit s402, bit s);
    @(negedge clk);
    rstn = r; mwr = wr; mdin = d; mrd = rd; extdet = ext;
    srd40a = s40r; swr40a = s40w; srd402 = s402; shst = s;
    q.push_back(expect_now(rd, ext));
    @(posedge clk);
    model_step(r, wr, d, s40r, s40w, s402, s);
  endtask

  task automatic idle(bit s);
    cyc(1, 0, 8'h00, 1, 0, 0, 0, 0, s);
  endtask

  // Monitor: compare DUT outputs mid-low-phase against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      if (shaltn !== e.shaltn) begin
        miscompares++;
        $display("FAIL shaltn @%0t actual=%b required=%b", $time, shaltn, e.shaltn);
      end
      if (subirqn !== e.subirqn) begin
        miscompares++;
        $display("FAIL subirqn @%0t actual=%b required=%b", $time, subirqn, e.subirqn);
      end
      if (sub_halted !== e.halted) begin
        miscompares++;
        $display("FAIL sub_halted @%0t actual=%b required=%b", $time, sub_halted, e.halted);
      end
      if (mdout !== e.rd) begin
        miscompares++;
        $display("FAIL readback @%0t actual=%h required=%h", $time, mdout, e.rd);
      end
    end
  end

  initial begin
    rstn = 0; mwr = 0; mdin = 0; mrd = 0; extdet = 0;
    srd40a = 0; swr40a = 0; srd402 = 0; shst = 1;
    repeat (2) @(posedge clk);

    // Reset values
    repeat (3) cyc(0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    idle(1);
    // Halt handshake
    cyc(1, 1, 8'h80, 1, 0, 0, 0, 0, 1);
    idle(1); idle(1);
    repeat (3) idle(0);
    // Release, then glitch during a new request
    cyc(1, 1, 8'h00, 1, 0, 0, 0, 0, 1);
    repeat (3) idle(1);
    cyc(1, 1, 8'h80, 1, 1, 0, 0, 0, 1);
    idle(0); idle(1); idle(0); idle(0); idle(0);
    cyc(1, 1, 8'h00, 1, 0, 0, 0, 0, 0);
    idle(1); idle(1); idle(1);
    // Cancel IRQ collision then lone acknowledge
    cyc(1, 1, 8'h40, 1, 0, 0, 0, 1, 1);
    idle(1);
    cyc(1, 0, 8'h00, 1, 0, 0, 0, 1, 1);
    idle(1);
    // Busy flag clear, then set/clear collision
    cyc(1, 0, 8'h00, 1, 0, 0, 1, 0, 1);
    idle(1);
    cyc(1, 0, 8'h00, 1, 0, 1, 1, 0, 1);
    idle(1);
    // Reset while in REQ with SHALTSTn low
    cyc(1, 1, 8'h80, 1, 0, 0, 0, 0, 0);
    idle(0);
    cyc(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    idle(0); idle(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit s_next;
      s_next = ($urandom_range(0, 3) == 0) ? !shst : shst;
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 5) == 0,
          8'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, s_next);
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
    #4;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sub_halt_ctrl
`default_nettype wire
